// File: rtl/mod_csr_access_unit.sv
// mod_csr_access_unit
// Initiator side of the CSR register-file port. Runs one Zicsr instruction
// (CSRRW/CSRRS/CSRRC and the immediate forms) per request as a
// read-modify-write sequence. Applies the rd=x0 / rs1=x0 access-suppression
// rules and folds the register file's error signals into one illegal flag.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   req_*                      request from execute (valid/ready) and fields
//   resp_*                     response to execute (valid/ready), rd data,
//                              rd write enable, illegal-instruction flag
//   csr_read_* / csr_write_*   address, enable and data to the CSR file
//   csr_*_nonexist_i,
//   csr_wr_readonly_i          access errors reported by the CSR file
//
// State | meaning
// IDLE  | ready for a request; CSR address outputs held at 0
// READ  | read enable high, old value latched
// WRITE | single-cycle write enable with the modified value
// RESP  | response presented, held until resp_ready_i

module mod_csr_access_unit #(
  parameter int XLEN       = 32,
  parameter int CSR_ADDR_W = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            req_funct3_i,
  input  logic [CSR_ADDR_W-1:0] req_csr_addr_i,
  input  logic [XLEN-1:0]       req_rs1_val_i,
  input  logic [4:0]            req_uimm_i,
  input  logic                  req_rd_nz_i,
  input  logic                  req_rs1_nz_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [XLEN-1:0]       resp_rd_val_o,
  output logic                  resp_rd_we_o,
  output logic                  resp_illegal_o,
  output logic [CSR_ADDR_W-1:0] csr_read_addr_o,
  output logic                  csr_read_enable_o,
  input  logic [XLEN-1:0]       csr_read_val_i,
  output logic [CSR_ADDR_W-1:0] csr_write_addr_o,
  output logic [XLEN-1:0]       csr_write_val_o,
  output logic                  csr_write_enable_o,
  input  logic                  csr_rd_nonexist_i,
  input  logic                  csr_wr_nonexist_i,
  input  logic                  csr_wr_readonly_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // funct3[1:0]: 01 write, 10 set, 11 clear, 00 illegal. funct3[2] selects
  // the immediate form, which only affects the source operand, so it is
  // folded into r_src at capture and not kept.
  logic [1:0]            r_op;
  logic [CSR_ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]       r_src;
  logic                  r_rd_nz;
  logic                  r_rs1_nz;
  logic [XLEN-1:0]       r_old;
  logic                  r_illegal;
  logic                  r_did_read;

  logic                  w_req_hs;
  logic                  w_req_f3_illegal;
  logic                  w_req_do_read;
  logic [XLEN-1:0]       w_req_src;
  logic                  w_do_write;
  logic [XLEN-1:0]       w_wr_val;

  assign w_req_hs         = req_valid_i && (r_state == ST_IDLE);
  assign w_req_f3_illegal = (req_funct3_i[1:0] == 2'b00);
  // A plain write with rd=x0 must not read the CSR (no read side effects).
  assign w_req_do_read    = !((req_funct3_i[1:0] == 2'b01) && !req_rd_nz_i);
  assign w_req_src        = req_funct3_i[2] ? {{(XLEN-5){1'b0}}, req_uimm_i}
                                            : req_rs1_val_i;
  // Set/clear with rs1=x0 (or zimm=0) must not write the CSR.
  assign w_do_write       = (r_op == 2'b01) || r_rs1_nz;

  always_comb begin
    w_wr_val = r_src;
    case (r_op)
      2'b10:   w_wr_val = r_old | r_src;
      2'b11:   w_wr_val = r_old & ~r_src;
      default: w_wr_val = r_src;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    req_ready_o        = 1'b0;
    resp_valid_o       = 1'b0;
    resp_rd_val_o      = '0;
    resp_rd_we_o       = 1'b0;
    resp_illegal_o     = 1'b0;
    csr_read_addr_o    = '0;
    csr_read_enable_o  = 1'b0;
    csr_write_addr_o   = '0;
    csr_write_val_o    = '0;
    csr_write_enable_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (w_req_f3_illegal) begin
            w_state_nxt = ST_RESP;
          end else if (w_req_do_read) begin
            w_state_nxt = ST_READ;
          end else begin
            w_state_nxt = ST_WRITE;
          end
        end
      end
      ST_READ: begin
        csr_read_addr_o   = r_addr;
        csr_write_addr_o  = r_addr;
        csr_read_enable_o = 1'b1;
        if (csr_rd_nonexist_i || !w_do_write) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        csr_read_addr_o    = r_addr;
        csr_write_addr_o   = r_addr;
        csr_write_val_o    = w_wr_val;
        csr_write_enable_o = 1'b1;
        w_state_nxt        = ST_RESP;
      end
      ST_RESP: begin
        csr_read_addr_o  = r_addr;
        csr_write_addr_o = r_addr;
        resp_valid_o     = 1'b1;
        resp_rd_val_o    = (r_did_read && !r_illegal) ? r_old : '0;
        resp_rd_we_o     = r_rd_nz && !r_illegal;
        resp_illegal_o   = r_illegal;
        if (resp_ready_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op       <= '0;
      r_addr     <= '0;
      r_src      <= '0;
      r_rd_nz    <= 1'b0;
      r_rs1_nz   <= 1'b0;
      r_old      <= '0;
      r_illegal  <= 1'b0;
      r_did_read <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_hs) begin
            r_op       <= req_funct3_i[1:0];
            r_addr     <= req_csr_addr_i;
            r_src      <= w_req_src;
            r_rd_nz    <= req_rd_nz_i;
            r_rs1_nz   <= req_rs1_nz_i;
            r_old      <= '0;
            r_illegal  <= w_req_f3_illegal;
            r_did_read <= 1'b0;
          end
        end
        ST_READ: begin
          r_old <= csr_read_val_i;
          if (csr_rd_nonexist_i) begin
            r_illegal <= 1'b1;
          end else begin
            r_did_read <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (csr_wr_nonexist_i || csr_wr_readonly_i) begin
            r_illegal <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_csr_access_unit.sv
module tb_mod_csr_access_unit;

  logic        clk_i;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_funct3_i;
  logic [11:0] req_csr_addr_i;
  logic [31:0] req_rs1_val_i;
  logic [4:0]  req_uimm_i;
  logic        req_rd_nz_i;
  logic        req_rs1_nz_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rd_val_o;
  logic        resp_rd_we_o;
  logic        resp_illegal_o;
  logic [11:0] csr_read_addr_o;
  logic        csr_read_enable_o;
  logic [31:0] csr_read_val_i;
  logic [11:0] csr_write_addr_o;
  logic [31:0] csr_write_val_o;
  logic        csr_write_enable_o;
  logic        csr_rd_nonexist_i;
  logic        csr_wr_nonexist_i;
  logic        csr_wr_readonly_i;

  mod_csr_access_unit #(.XLEN(32), .CSR_ADDR_W(12)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_funct3_i       (req_funct3_i),
    .req_csr_addr_i     (req_csr_addr_i),
    .req_rs1_val_i      (req_rs1_val_i),
    .req_uimm_i         (req_uimm_i),
    .req_rd_nz_i        (req_rd_nz_i),
    .req_rs1_nz_i       (req_rs1_nz_i),
    .resp_valid_o       (resp_valid_o),
    .resp_ready_i       (resp_ready_i),
    .resp_rd_val_o      (resp_rd_val_o),
    .resp_rd_we_o       (resp_rd_we_o),
    .resp_illegal_o     (resp_illegal_o),
    .csr_read_addr_o    (csr_read_addr_o),
    .csr_read_enable_o  (csr_read_enable_o),
    .csr_read_val_i     (csr_read_val_i),
    .csr_write_addr_o   (csr_write_addr_o),
    .csr_write_val_o    (csr_write_val_o),
    .csr_write_enable_o (csr_write_enable_o),
    .csr_rd_nonexist_i  (csr_rd_nonexist_i),
    .csr_wr_nonexist_i  (csr_wr_nonexist_i),
    .csr_wr_readonly_i  (csr_wr_readonly_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Small CSR file: six implemented CSRs; 0xF14 (mhartid) is read-only.
  function automatic int csr_idx(input logic [11:0] a);
    case (a)
      12'h300: return 0;
      12'h304: return 1;
      12'h305: return 2;
      12'h340: return 3;
      12'h342: return 4;
      12'hF14: return 5;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] csr_init(input int i);
    case (i)
      0: return 32'h0000_1800;
      1: return 32'h0000_0888;
      2: return 32'h0000_0080;
      3: return 32'hDEAD_BEEF;
      4: return 32'h0000_000F;
      default: return 32'h0000_0003;
    endcase
  endfunction

  logic [31:0] env_mem [8];
  bit env_loaded = 1'b0;
  int rd_i, wr_i;

  always_comb begin
    rd_i = csr_idx(csr_read_addr_o);
    wr_i = csr_idx(csr_write_addr_o);
    csr_read_val_i    = (rd_i >= 0) ? env_mem[rd_i[2:0]] : 32'h0;
    csr_rd_nonexist_i = csr_read_enable_o && (rd_i < 0);
    csr_wr_nonexist_i = csr_write_enable_o && (wr_i < 0);
    csr_wr_readonly_i = csr_write_enable_o && (wr_i >= 0) && (csr_write_addr_o[11:10] == 2'b11);
  end

  always @(posedge clk_i) begin
    if (!env_loaded) begin
      for (int i = 0; i < 8; i++) env_mem[i] <= csr_init(i);
      env_loaded <= 1'b1;
    end else if (csr_write_enable_o && wr_i >= 0 && csr_write_addr_o[11:10] != 2'b11) begin
      env_mem[wr_i[2:0]] <= csr_write_val_o;
    end
  end

  typedef struct {
    logic [31:0] rd_val;
    logic        we;
    logic        ill;
    int          lat;
    int          hs;
    logic [11:0] addr;
  } resp_t;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] val;
  } wr_t;

  resp_t exp_q[$];
  wr_t   wr_q[$];
  logic [31:0] ref_mem [8];
  int hold_reqs = 0;

  // Monitor / scoreboard.
  bit          in_resp = 1'b0;
  int          hold_done = 0;
  int          hold_cnt = 0;
  logic [31:0] cur_rd_val;
  logic        cur_we, cur_ill;
  resp_t       e;
  wr_t         w;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      in_resp      = 1'b0;
      hold_cnt     = 0;
      resp_ready_i = 1'b0;
    end else begin
      if (csr_read_enable_o && csr_write_enable_o) chk("rd_wr_both", 32'd1, 32'd0);
      if (req_ready_o) begin
        chk("idle_rd_addr", {20'h0, csr_read_addr_o}, 32'h0);
        chk("idle_wr_addr", {20'h0, csr_write_addr_o}, 32'h0);
      end
      if (csr_read_enable_o) begin
        if (exp_q.size() == 0) chk("unexpected_read", 32'd1, 32'd0);
        else chk("read_addr", {20'h0, csr_read_addr_o}, {20'h0, exp_q[0].addr});
      end
      if (csr_write_enable_o) begin
        if (wr_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          w = wr_q.pop_front();
          chk("write_addr", {20'h0, csr_write_addr_o}, {20'h0, w.addr});
          chk("write_val", csr_write_val_o, w.val);
        end
      end
      if (resp_valid_o) begin
        if (!in_resp) begin
          if (exp_q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("rd_val", resp_rd_val_o, e.rd_val);
            chk("rd_we", {31'h0, resp_rd_we_o}, {31'h0, e.we});
            chk("illegal", {31'h0, resp_illegal_o}, {31'h0, e.ill});
            chk("latency", cyc - e.hs + 1, e.lat);
          end
          cur_rd_val = resp_rd_val_o;
          cur_we     = resp_rd_we_o;
          cur_ill    = resp_illegal_o;
          in_resp    = 1'b1;
          if (hold_reqs > hold_done) begin
            hold_done++;
            hold_cnt = 5;
          end
        end else begin
          chk("hold_rd_val", resp_rd_val_o, cur_rd_val);
          chk("hold_flags", {30'h0, resp_rd_we_o, resp_illegal_o}, {30'h0, cur_we, cur_ill});
        end
        chk("busy_ready", {31'h0, req_ready_o}, 32'h0);
        if (hold_cnt > 0) begin
          resp_ready_i = 1'b0;
          hold_cnt--;
        end else begin
          resp_ready_i = ($urandom_range(0, 2) != 0);
        end
        if (resp_ready_i) in_resp = 1'b0;
      end else begin
        resp_ready_i = $urandom_range(0, 1) != 0;
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] rs1,
                       input logic [4:0] uimm, input logic rd_nz, input logic rs1_nz);
    int n = 0;
    int ix;
    bit ex, ro, ill, rw, rs, dr, dw, do_wr;
    logic [31:0] src, old, nv;
    resp_t r;
    wr_t   wx;
    @(negedge clk_i);
    while (!req_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!req_ready_o) chk("req_ready_timeout", 32'd0, 32'd1);
    req_valid_i    = 1'b1;
    req_funct3_i   = f3;
    req_csr_addr_i = addr;
    req_rs1_val_i  = rs1;
    req_uimm_i     = uimm;
    req_rd_nz_i    = rd_nz;
    req_rs1_nz_i   = rs1_nz;
    // Reference: Zicsr semantics over the shadow CSR array.
    ix    = csr_idx(addr);
    ex    = (ix >= 0);
    ro    = (addr[11:10] == 2'b11);
    ill   = (f3 == 3'd0 || f3 == 3'd4);
    rw    = (f3 == 3'd1 || f3 == 3'd5);
    rs    = (f3 == 3'd2 || f3 == 3'd6);
    src   = (f3 >= 3'd4) ? {27'h0, uimm} : rs1;
    dr    = !(rw && !rd_nz);
    dw    = rw || rs1_nz;
    old   = ex ? ref_mem[ix[2:0]] : 32'h0;
    do_wr = 1'b0;
    nv    = 32'h0;
    if (ill) r.lat = 1;
    else if (dr && !ex) begin
      ill   = 1'b1;
      r.lat = 2;
    end else begin
      r.lat = 1 + int'(dr) + int'(dw);
      if (dw) begin
        do_wr = 1'b1;
        nv = rw ? src : (rs ? (old | src) : (old & ~src));
        if (!ex || ro) ill = 1'b1;
        else ref_mem[ix[2:0]] = nv;
      end
    end
    r.rd_val = (dr && !ill) ? old : 32'h0;
    r.we     = rd_nz && !ill;
    r.ill    = ill;
    r.addr   = addr;
    @(posedge clk_i);
    #1;
    r.hs = cyc;
    exp_q.push_back(r);
    if (do_wr) begin
      wx.addr = addr;
      wx.val  = nv;
      wr_q.push_back(wx);
    end
    req_valid_i    = 1'b0;
    req_funct3_i   = 3'($urandom);
    req_csr_addr_i = 12'($urandom);
    req_rs1_val_i  = $urandom;
    req_uimm_i     = 5'($urandom);
    req_rd_nz_i    = 1'($urandom);
    req_rs1_nz_i   = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || resp_valid_o) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("drain_resp_q", exp_q.size(), 0);
    chk("drain_wr_q", wr_q.size(), 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  logic [11:0] addr_tab [8];
  logic [31:0] saved;
  int n;

  initial begin
    addr_tab[0] = 12'h300; addr_tab[1] = 12'h304; addr_tab[2] = 12'h305; addr_tab[3] = 12'h340;
    addr_tab[4] = 12'h342; addr_tab[5] = 12'hF14; addr_tab[6] = 12'h7FF; addr_tab[7] = 12'h7C0;
    for (int i = 0; i < 8; i++) ref_mem[i] = csr_init(i);
    rst_ni = 1'b0;
    req_valid_i = 1'b0; req_funct3_i = 3'h0; req_csr_addr_i = 12'h0; req_rs1_val_i = 32'h0;
    req_uimm_i = 5'h0; req_rd_nz_i = 1'b0; req_rs1_nz_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_req_ready", {31'h0, req_ready_o}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid_o}, 32'h0);
    chk("rst_enables", {30'h0, csr_read_enable_o, csr_write_enable_o}, 32'h0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    issue(3'd1, 12'h305, 32'h0000_1000, 5'd0, 1'b1, 1'b1);  // CSRRW mtvec
    issue(3'd2, 12'h304, 32'h1234_5678, 5'd0, 1'b1, 1'b0);  // CSRRS mie, rs1=x0
    issue(3'd7, 12'h342, 32'h0, 5'd3, 1'b1, 1'b1);          // CSRRCI mcause
    issue(3'd1, 12'hF14, 32'h0000_00AA, 5'd0, 1'b1, 1'b1);  // CSRRW mhartid
    issue(3'd2, 12'h7FF, 32'h0000_0001, 5'd0, 1'b1, 1'b1);  // CSRRS nonexistent
    issue(3'd5, 12'h340, 32'h0, 5'd9, 1'b0, 1'b1);          // CSRRWI rd=x0
    hold_reqs = 1;
    issue(3'd4, 12'h300, 32'h0, 5'd0, 1'b1, 1'b1);          // illegal funct3
    drain();

    // Reset during the WRITE cycle of a CSRRW.
    saved = ref_mem[3];
    issue(3'd1, 12'h340, 32'h5555_AAAA, 5'd0, 1'b1, 1'b1);
    n = 0;
    while (!csr_write_enable_o && n < 10) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    chk("reset_reached_write", {31'h0, csr_write_enable_o}, 32'h1);
    rst_ni = 1'b0;
    #1;
    chk("abort_req_ready", {31'h0, req_ready_o}, 32'h1);
    chk("abort_ctrl", {27'h0, resp_valid_o, resp_rd_we_o, resp_illegal_o,
                       csr_read_enable_o, csr_write_enable_o}, 32'h0);
    chk("abort_addr", {csr_read_addr_o, csr_write_addr_o}, 24'h0);
    chk("abort_data", csr_write_val_o | resp_rd_val_o, 32'h0);
    exp_q.delete();
    wr_q.delete();
    ref_mem[3] = saved;
    repeat (3) @(negedge clk_i);
    #2 rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);
    chk("post_reset_ready", {31'h0, req_ready_o}, 32'h1);
    issue(3'd2, 12'h340, 32'h0, 5'd0, 1'b1, 1'b0);          // mscratch unchanged
    drain();

    for (int k = 0; k < 300; k++) begin
      logic [2:0] f3;
      logic [4:0] u;
      logic rsnz;
      f3 = 3'($urandom);
      u  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      if (f3[2]) rsnz = (u != 5'd0);
      else rsnz = ($urandom_range(0, 3) != 0);
      if (k % 50 == 25) hold_reqs = hold_reqs + 1;
      issue(f3, addr_tab[$urandom_range(0, 7)], $urandom, u, 1'($urandom), rsnz);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_csr_access_unit.md
Name: mod_csr_access_unit

Overview:
- Initiator side of the CSR register-file port. Executes one Zicsr instruction per request: CSRRW, CSRRS, CSRRC and their immediate forms.
- Sequences the read-modify-write against the CSR register file and applies the rd=x0 / rs1=x0 access-suppression rules.
- Folds the register file's illegal-access signals into a single illegal-instruction flag.
- Sits between the execute stage (valid/ready request and response) and the CSR register file.

Parameters:
- XLEN, `XLEN, data width of CSR values and rs1.
- CSR_ADDR_W, `CSR_ADDR_WIDTH, CSR address width (12).

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  unit can accept a request
- req_funct3_i  in  3  instruction funct3 field
- req_csr_addr_i  in  CSR_ADDR_W  target CSR address
- req_rs1_val_i  in  XLEN  rs1 register value
- req_uimm_i  in  5  rs1 field used as zimm
- req_rd_nz_i  in  1  rd field != x0
- req_rs1_nz_i  in  1  rs1/zimm field != 0
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response consumed
- resp_rd_val_o  out  XLEN  old CSR value for rd
- resp_rd_we_o  out  1  write rd
- resp_illegal_o  out  1  raise illegal-instruction exception
- csr_read_addr_o  out  CSR_ADDR_W  to CSR file
- csr_read_enable_o  out  1  to CSR file
- csr_read_val_i  in  XLEN  combinational read data from CSR file
- csr_write_addr_o  out  CSR_ADDR_W  to CSR file
- csr_write_val_o  out  XLEN  to CSR file
- csr_write_enable_o  out  1  to CSR file
- csr_rd_nonexist_i  in  1  read of non-existent CSR
- csr_wr_nonexist_i  in  1  write to non-existent CSR
- csr_wr_readonly_i  in  1  write to read-only CSR

Behaviour:

Reset:
- rst_ni low → state IDLE.
- All outputs 0 except req_ready_o=1.
- Captured registers are cleared.
- A reset asserted mid-operation aborts the instruction: no write enable is asserted after reset assertion and no response is produced.

Request capture:
- Handshake req_valid_i & req_ready_o (IDLE only) latches all req_* fields.
- Inputs are ignored in all other states.

Operation decode and source:
- Decode funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- funct3 000 or 100 → illegal.
- Source operand src = rs1_val for register forms; zero-extended uimm for immediate forms.

Access suppression:
- do_read = !(RW/RWI && !rd_nz).
- do_write = RW/RWI || rs1_nz.

State machine (Moore outputs):
- IDLE → READ if do_read; → WRITE if !do_read; → RESP if funct3 is illegal (illegal=1).
- READ:
  - csr_read_enable_o=1, csr_read_addr_o=captured address.
  - Latch old=csr_read_val_i.
  - If csr_rd_nonexist_i: illegal=1, go to RESP, no write.
  - Otherwise go to WRITE if do_write, else RESP.
- WRITE:
  - csr_write_enable_o=1 for exactly one cycle, csr_write_addr_o=captured address.
  - csr_write_val_o: RW → src; RS → old | src; RC → old & ~src.
  - If csr_wr_nonexist_i or csr_wr_readonly_i is sampled high: illegal=1.
  - The CSR file does not commit writes to those addresses.
  - Go to RESP.
- RESP:
  - resp_valid_o=1.
  - resp_rd_val_o = old if read performed and !illegal, else 0.
  - resp_rd_we_o = rd_nz && !illegal.
  - resp_illegal_o = illegal.
  - Outputs are held stable until resp_ready_i; on handshake go to IDLE.

Latency:
- Full RMW: resp_valid_o 3 cycles after request handshake.
- Read-only or write-only: 2 cycles.
- Illegal funct3: 1 cycle.
- Throughput: at most one instruction in flight.

Other rules:
- csr_*_addr_o = captured address whenever not in IDLE; 0 in IDLE.
- Read and write enables are never high in the same cycle.

Test Plan:
- CSRRW mtvec, rs1=0x0000_1000, rd_nz=1, old mtvec=0x80 → READ then WRITE of 0x1000; resp rd_val=0x80, rd_we=1, illegal=0, valid 3 cycles after accept.
- CSRRS mie, rs1_nz=0, rd_nz=1 → read only, csr_write_enable_o never asserted; resp after 2 cycles with the current mie value.
- CSRRCI mcause, uimm=0x3, old=0xF → write value 0xC; resp rd_val=0xF.
- CSRRW mhartid (read-only) → write cycle sees csr_wr_readonly_i=1; resp illegal=1, rd_we=0, rd_val=0. CSRRS on address 0x7FF → csr_rd_nonexist_i=1; no write enable, illegal=1.
- funct3=100 → resp illegal=1 after 1 cycle. Hold resp_ready_i low for 5 cycles → response fields stable and req_ready_o=0 throughout.
- Drop rst_ni during the WRITE cycle of a CSRRW → all outputs 0 immediately; after release, IDLE with req_ready_o=1 and no spurious response.
